anf_fl_tex_mem_write: RTL

Texture data writer: accepts one 128-bit colour packet (four RGBA8888 texels) addressed by pixel coordinates and texture metadata, bounds-checks it, and writes it to memory as four 32-bit beats on the memory write port. It is the write-side counterpart of the texture fetch path and sits between the render-target/texture-upload logic and the memory arbiter.

---
 rtl/anfFl_tex_pkg.sv | 35 +++
 rtl/anfFl_tex_addrCalc.sv | 26 ++
 rtl/anf_fl_tex_mem_write.sv | 114 +++++++++++
 3 files changed

// File: rtl/anfFl_tex_pkg.sv
// Shared definitions for the texture write and fetch paths: texMeta layout,
// packet/beat geometry and the writer FSM encoding.
package anfFl_tex_pkg;

  // texMeta = {height[15:0], width[15:0], base[31:0]}
  localparam int TEX_META_BASE_LSB   = 0;
  localparam int TEX_META_BASE_W     = 32;
  localparam int TEX_META_WIDTH_LSB  = 32;
  localparam int TEX_META_WIDTH_W    = 16;
  localparam int TEX_META_HEIGHT_LSB = 48;
  localparam int TEX_META_HEIGHT_W   = 16;

  localparam int TEX_PKT_BEATS  = 4;
  localparam int TEX_BEAT_BYTES = 4;
  localparam int TEX_BEAT_BITS  = 8 * TEX_BEAT_BYTES;

  typedef enum logic {
    TEX_IDLE  = 1'b0,
    TEX_WRITE = 1'b1
  } tex_state_e;

  // A packet is refused when its first texel is outside the texture, it is not
  // 4-texel aligned, or the texture has no columns at all.
  function automatic logic tex_reject(input logic [15:0] x,
                                      input logic [15:0] y,
                                      input logic [15:0] width,
                                      input logic [15:0] height);
    return (x >= width) || (y >= height) || (x[1:0] != 2'b00) || (width == 16'd0);
  endfunction

  function automatic logic [31:0] tex_beat_offset(input logic [1:0] beat);
    return 32'(beat) * 32'(TEX_BEAT_BYTES);
  endfunction

endpackage

// File: rtl/anfFl_tex_addrCalc.sv
// Pixel-to-byte-address mapping shared by the texture read and write paths.
// Purely combinational; all arithmetic is 32-bit unsigned and wraps.
module anfFl_tex_addrCalc
  import anfFl_tex_pkg::*;
(
  input  logic [15:0] y,
  input  logic [15:0] x,
  input  logic [63:0] texMeta,
  output logic [31:0] pktAddr
);

  logic [31:0] base;
  logic [31:0] width;
  logic [31:0] texel_idx;
  logic        unused_height;

  assign base  = texMeta[TEX_META_BASE_LSB +: TEX_META_BASE_W];
  assign width = {16'd0, texMeta[TEX_META_WIDTH_LSB +: TEX_META_WIDTH_W]};

  // Height only matters for bounds checking, which the callers do themselves.
  assign unused_height = ^texMeta[TEX_META_HEIGHT_LSB +: TEX_META_HEIGHT_W];

  assign texel_idx = (32'(y) * width) + 32'(x);
  assign pktAddr   = base + (texel_idx << 2);

endmodule

// File: rtl/anf_fl_tex_mem_write.sv
// Texture packet writer: bounds-checks a 4-texel colour packet and emits it as
// four 32-bit memory write beats, holding each beat until the memory accepts it.
module anf_fl_tex_mem_write
  import anfFl_tex_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         reqValid,
  output logic         reqReady,
  input  logic [15:0]  yPixel,
  input  logic [15:0]  xPixel,
  input  logic [63:0]  texMeta,
  input  logic [127:0] colorPkt,
  output logic         done,
  output logic         oobErr,
  output logic [31:0]  memWrAddr,
  output logic [31:0]  memWrData,
  output logic         memWrValid,
  input  logic         memWrReady
);

  localparam logic [1:0] LAST_BEAT = 2'(TEX_PKT_BEATS - 1);

  tex_state_e   state;
  logic [1:0]   beat;
  logic [1:0]   next_beat;
  logic [127:0] pkt;
  logic [31:0]  pkt_addr;
  logic [31:0]  calc_addr;
  logic [15:0]  meta_width;
  logic [15:0]  meta_height;
  logic         accept;
  logic         reject;
  logic         beat_fire;

  anfFl_tex_addrCalc u_addr_calc (
    .y       (yPixel),
    .x       (xPixel),
    .texMeta (texMeta),
    .pktAddr (calc_addr)
  );

  assign meta_width  = texMeta[TEX_META_WIDTH_LSB  +: TEX_META_WIDTH_W];
  assign meta_height = texMeta[TEX_META_HEIGHT_LSB +: TEX_META_HEIGHT_W];

  assign accept    = reqValid && reqReady;
  assign reject    = tex_reject(xPixel, yPixel, meta_width, meta_height);
  assign beat_fire = memWrValid && memWrReady;
  assign next_beat = beat + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= TEX_IDLE;
      beat       <= 2'd0;
      pkt        <= '0;
      pkt_addr   <= '0;
      reqReady   <= 1'b1;
      done       <= 1'b0;
      oobErr     <= 1'b0;
      memWrValid <= 1'b0;
      memWrAddr  <= '0;
      memWrData  <= '0;
    end else begin
      done   <= 1'b0;
      oobErr <= 1'b0;

      case (state)
        TEX_IDLE: begin
          if (accept) begin
            if (reject) begin
              oobErr <= 1'b1;
            end else begin
              // Beat 0 is presented straight from the request so it is valid
              // the cycle after the accept edge.
              state      <= TEX_WRITE;
              beat       <= 2'd0;
              pkt        <= colorPkt;
              pkt_addr   <= calc_addr;
              reqReady   <= 1'b0;
              memWrValid <= 1'b1;
              memWrAddr  <= calc_addr;
              memWrData  <= colorPkt[TEX_BEAT_BITS-1:0];
            end
          end
        end

        TEX_WRITE: begin
          if (beat_fire) begin
            if (beat == LAST_BEAT) begin
              state      <= TEX_IDLE;
              beat       <= 2'd0;
              reqReady   <= 1'b1;
              done       <= 1'b1;
              memWrValid <= 1'b0;
              memWrAddr  <= '0;
              memWrData  <= '0;
            end else begin
              beat      <= next_beat;
              memWrAddr <= pkt_addr + tex_beat_offset(next_beat);
              memWrData <= pkt[TEX_BEAT_BITS*next_beat +: TEX_BEAT_BITS];
            end
          end
        end

        default: begin
          state      <= TEX_IDLE;
          reqReady   <= 1'b1;
          memWrValid <= 1'b0;
        end
      endcase
    end
  end

endmodule
